// File: rtl/mips_cache_controller.sv
// mips_cache_controller: word-granular miss/write sequencer between the MIPS
// data cache and an Avalon-style memory bus. Read misses fetch one word and
// hand it to the cache. Writes are write-through, and a write miss allocates
// (fetch, fill) before the write.
// Optional feature: define MIPS_CACHE_CTRL_PERF_EN to add the hit_count and
// miss_count outputs.
module mips_cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] writedata,
  input  logic [3:0]  byte_en,
  input  logic        cache_stall,
  output logic        cpu_stall,
  output logic [31:0] data_in,
  output logic        data_valid,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
`ifdef MIPS_CACHE_CTRL_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, FILL, WRITE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [29:0] req_addr_reg;
  logic [31:0] req_wdata_reg;
  logic [3:0]  req_be_reg;
  logic        req_is_write_reg;
  logic [31:0] fill_data_reg;

  // The byte offset is irrelevant; the bus is always word-addressed.
  logic addr_unused;
  assign addr_unused = ^addr[1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic. In IDLE, a read takes priority over a write.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (read_en) begin
          if (cache_stall) state_next = FETCH;
        end else if (write_en) begin
          state_next = cache_stall ? FETCH : WRITE;
        end
      end
      FETCH:   if (!mem_waitrequest) state_next = FILL;
      FILL:    state_next = req_is_write_reg ? WRITE : IDLE;
      WRITE:   if (!mem_waitrequest) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. Bus strobes are decoded from the state, so they can never overlap.
  always_comb begin
    mem_read       = (state_reg == FETCH);
    mem_write      = (state_reg == WRITE);
    data_valid     = (state_reg == FILL);
    cpu_stall      = 1'b0;
    data_in        = fill_data_reg;
    mem_address    = {req_addr_reg, 2'b00};
    mem_writedata  = req_wdata_reg;
    mem_byteenable = req_be_reg;
    case (state_reg)
      IDLE:    cpu_stall = (read_en & cache_stall) | write_en;
      FETCH:   begin cpu_stall = 1'b1; mem_byteenable = 4'b1111; end
      FILL:    begin cpu_stall = 1'b1; data_in = mem_readdata; end
      WRITE:   cpu_stall = 1'b1;
      default: cpu_stall = 1'b0;
    endcase
  end

  // Latch the request when it is accepted in IDLE, and keep the last fill word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr_reg     <= '0;
      req_wdata_reg    <= '0;
      req_be_reg       <= '0;
      req_is_write_reg <= 1'b0;
      fill_data_reg    <= '0;
    end else begin
      if (state_reg == IDLE) begin
        if (read_en) begin
          if (cache_stall) begin
            req_addr_reg     <= addr[31:2];
            req_is_write_reg <= 1'b0;
          end
        end else if (write_en) begin
          req_addr_reg     <= addr[31:2];
          req_wdata_reg    <= writedata;
          req_be_reg       <= byte_en;
          req_is_write_reg <= 1'b1;
        end
      end
      if (state_reg == FILL) fill_data_reg <= mem_readdata;
    end
  end

`ifdef MIPS_CACHE_CTRL_PERF_EN
  // Performance counters: hits are IDLE accepts without a tag miss, and
  // misses are IDLE->FETCH transitions. Both wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_reg == IDLE && (read_en | write_en) && !cache_stall)
        hit_count <= hit_count + 32'd1;
      if (state_reg == IDLE && state_next == FETCH)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_cache_controller.sv
// tb_mips_cache_controller: directed stimulus with a bus/fill event scoreboard.
// The stimulus pushes expected bus and fill events. A monitor pops them and
// compares them whenever the DUT shows an accepted bus request or a fill strobe.
module tb_mips_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        read_en, write_en;
  logic [31:0] writedata;
  logic [3:0]  byte_en;
  logic        cache_stall;
  logic        cpu_stall;
  logic [31:0] data_in;
  logic        data_valid;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
`ifdef MIPS_CACHE_CTRL_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  mips_cache_controller dut (
    .clk(clk), .rst(rst), .addr(addr), .read_en(read_en), .write_en(write_en),
    .writedata(writedata), .byte_en(byte_en), .cache_stall(cache_stall),
    .cpu_stall(cpu_stall), .data_in(data_in), .data_valid(data_valid),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
`ifdef MIPS_CACHE_CTRL_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 = bus read, 1 = fill, 2 = bus write
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  rd_cycles = 0, wr_cycles = 0, dv_cycles = 0;
  int  wait_cycles = 0;
  logic [31:0] rdata_val = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Compare one observed event against the head of the expectation queue.
  task automatic got(input logic [1:0] kind, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind=%0d addr=0x%08h data=0x%08h be=%b", kind, a, d, b);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", {30'd0, kind}, {30'd0, e.kind});
      if (e.kind != 2'd1) check("event_addr", a, e.a);
      if (e.kind != 2'd0) check("event_data", d, e.d);
      if (e.kind != 2'd1) check("event_be", {28'd0, b}, {28'd0, e.b});
      $display("event kind=%0d addr=0x%08h data=0x%08h be=%b", kind, a, d, b);
    end
  endtask

  // Monitor: sample at the falling edge, where all inputs are stable.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_read)   rd_cycles++;
        if (mem_write)  wr_cycles++;
        if (data_valid) dv_cycles++;
        if (mem_read || mem_write)
          check("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
        if (mem_read && !mem_waitrequest)  got(2'd0, mem_address, 32'd0, mem_byteenable);
        if (data_valid)                    got(2'd1, 32'd0, data_in, 4'd0);
        if (mem_write && !mem_waitrequest) got(2'd2, mem_address, mem_writedata, mem_byteenable);
      end
    end
  end

  // Memory slave model: wait_cycles of waitrequest per request, and read data
  // only in the cycle after a read is accepted.
  initial begin
    int  wcnt;
    logic acc;
    wcnt = 0;
    mem_waitrequest = 1'b0;
    mem_readdata = 32'hBADBAD00;
    forever begin
      @(negedge clk);
      acc = mem_read && !mem_waitrequest;
      @(posedge clk);
      #1;
      mem_readdata = acc ? rdata_val : 32'hBADBAD00;
      if ((mem_read || mem_write) && wcnt < wait_cycles) begin
        mem_waitrequest = 1'b1;
        wcnt++;
      end else begin
        mem_waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Issue one CPU request. Entered and left at posedge+1.
  task automatic run_op(input string name, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic cs, input int w, input logic [31:0] rdv,
                        input logic [31:0] ea, input int exp_stall, input int exp_rdc,
                        input int exp_wrc, input int exp_dv);
    int   n;
    logic stall_now;
    ev_t  e;
    if (exp_rdc > 0) begin e.kind = 2'd0; e.a = ea; e.d = 32'd0; e.b = 4'hF; exp_q.push_back(e); end
    if (exp_dv > 0)  begin e.kind = 2'd1; e.a = 32'd0; e.d = rdv; e.b = 4'd0; exp_q.push_back(e); end
    if (exp_wrc > 0) begin e.kind = 2'd2; e.a = ea; e.d = wd; e.b = be; exp_q.push_back(e); end
    rd_cycles = 0; wr_cycles = 0; dv_cycles = 0;
    read_en = rd; write_en = wr; addr = a; writedata = wd; byte_en = be;
    cache_stall = cs; wait_cycles = w; rdata_val = rdv;
    n = 0;
    @(negedge clk);
    stall_now = cpu_stall;
    if (stall_now) n++;
    @(posedge clk); #1;
    read_en = 1'b0; write_en = 1'b0; cache_stall = 1'b0;
    for (int i = 0; i < 50 && stall_now; i++) begin
      @(negedge clk);
      stall_now = cpu_stall;
      if (stall_now) n++;
      @(posedge clk); #1;
    end
    if (stall_now) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: cpu_stall still 1 after 50 cycles, required release", name);
    end
    check({name, "_stall_cycles"}, n, exp_stall);
    check({name, "_mem_read_cycles"}, rd_cycles, exp_rdc);
    check({name, "_mem_write_cycles"}, wr_cycles, exp_wrc);
    check({name, "_data_valid_cycles"}, dv_cycles, exp_dv);
    $display("op %s: stall=%0d rd=%0d wr=%0d dv=%0d", name, n, rd_cycles, wr_cycles, dv_cycles);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    read_en = 1'b0; write_en = 1'b0; addr = '0; writedata = '0;
    byte_en = '0; cache_stall = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_data_in", data_in, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_writedata", mem_writedata, 32'd0);
    check("rst_mem_byteenable", {28'd0, mem_byteenable}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset in the middle of a fetch abandons the transaction.
    read_en = 1'b1; cache_stall = 1'b1; addr = 32'h400; wait_cycles = 5;
    @(negedge clk);
    check("abort_idle_stall", {31'd0, cpu_stall}, 32'd1);
    @(posedge clk); #1;
    read_en = 1'b0; cache_stall = 1'b0;
    @(negedge clk);
    check("abort_fetch_read", {31'd0, mem_read}, 32'd1);
    check("abort_fetch_addr", mem_address, 32'h400);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_read_dropped", {31'd0, mem_read}, 32'd0);
    check("abort_addr_cleared", mem_address, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle_stall_released", {31'd0, cpu_stall}, 32'd0);
    check("abort_idle_no_read", {31'd0, mem_read}, 32'd0);
`ifdef MIPS_CACHE_CTRL_PERF_EN
    check("abort_hit_count", hit_count, 32'd0);
    check("abort_miss_count", miss_count, 32'd0);
`endif
    @(posedge clk); #1;

    //      name          rd    wr    addr          wdata         be       cs    W  rdata         exp addr      stall rd wr dv
    run_op("read_miss",   1'b1, 1'b0, 32'h00000100, 32'h0,        4'h0,    1'b1, 2, 32'hDEADBEEF, 32'h00000100, 5,    3, 0, 1);
    run_op("read_hit",    1'b1, 1'b0, 32'h00000100, 32'h0,        4'h0,    1'b0, 0, 32'h0,        32'h0,        0,    0, 0, 0);
    run_op("write_hit",   1'b0, 1'b1, 32'h00000104, 32'h12345678, 4'b0011, 1'b0, 0, 32'h0,        32'h00000104, 2,    0, 1, 0);
    run_op("write_miss",  1'b0, 1'b1, 32'h0000010B, 32'hCAFEF00D, 4'b1100, 1'b1, 1, 32'h55AA55AA, 32'h00000108, 6,    2, 2, 1);
    run_op("rd_priority", 1'b1, 1'b1, 32'h00000300, 32'hFFFFFFFF, 4'hF,    1'b1, 0, 32'h13579BDF, 32'h00000300, 3,    1, 0, 1);
    run_op("write_be0",   1'b0, 1'b1, 32'h0000020C, 32'hA5A5A5A5, 4'b0000, 1'b0, 1, 32'h0,        32'h0000020C, 3,    0, 2, 0);
    run_op("read_miss_w0",1'b1, 1'b0, 32'h00000200, 32'h0,        4'h0,    1'b1, 0, 32'h0BADF00D, 32'h00000200, 3,    1, 0, 1);

    @(negedge clk);
    check("data_in_held", data_in, 32'h0BADF00D);
    check("data_valid_idle", {31'd0, data_valid}, 32'd0);
    check("events_outstanding", exp_q.size(), 32'd0);
`ifdef MIPS_CACHE_CTRL_PERF_EN
    check("hit_count", hit_count, 32'd3);
    check("miss_count", miss_count, 32'd4);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
